// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and full/empty decode for the sync_fifo_param family.
package fifo_pkg;

   localparam int unsigned DEF_DSIZE = 8;
   localparam int unsigned DEF_ASIZE = 4;

   // Pointer for the default geometry: low ASIZE bits address, MSB is the wrap bit
   typedef logic [DEF_ASIZE:0] fifo_ptr_t;

   typedef struct packed {
      logic full;
      logic empty;
   } fifo_flags_t;

   // Pointers arrive zero-extended so any ASIZE up to 30 shares one decoder
   function automatic fifo_flags_t decode_flags(input logic [31:0] wptr,
                                                input logic [31:0] rptr,
                                                input int unsigned asize);
      logic [31:0] diff;
      fifo_flags_t f;
      diff    = (wptr ^ rptr) & ((32'd1 << (asize + 1)) - 32'd1);
      f.empty = (diff == '0);
      f.full  = (diff == (32'd1 << asize));
      return f;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE dual-port RAM: synchronous write, registered read port
// (asynchronous read port when SYNC_FIFO_FWFT_EN is defined).
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE = DEF_DSIZE,
   parameter int unsigned ASIZE = DEF_ASIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic             ren,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented directly; reset and read-enable have no role here
   logic unused_ctrl;
   assign unused_ctrl = rst ^ ren;
   assign rdata       = mem[raddr];
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (ren) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE     = DEF_DSIZE,
   parameter int unsigned ASIZE     = DEF_ASIZE,
   parameter int unsigned AFULL_TH  = (1 << ASIZE) - 2,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             walmost_full,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [31:0]  AFULL_W  = AFULL_TH;
   localparam logic [31:0]  AEMPTY_W = AEMPTY_TH;
   localparam logic [ASIZE:0] AFULL_C  = AFULL_W[ASIZE:0];
   localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_W[ASIZE:0];

   logic [ASIZE:0] wptr;
   logic [ASIZE:0] rptr;
   fifo_flags_t    flags;
   logic           wr_ok;
   logic           rd_ok;

   // All status is decoded from the registered pointers only
   assign flags         = decode_flags(32'(wptr), 32'(rptr), ASIZE);
   assign wfull         = flags.full;
   assign rempty        = flags.empty;
   assign count         = wptr - rptr;
   assign walmost_full  = (count >= AFULL_C);
   assign ralmost_empty = (count <= AEMPTY_C);

   assign wr_ok = winc && !flags.full;
   assign rd_ok = rinc && !flags.empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            rptr <= rptr + 1'b1;
         end
         if (winc && flags.full) begin
            overflow <= 1'b1;
         end
         if (rinc && flags.empty) begin
            underflow <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .wen   (wr_ok && !rst),
      .waddr (wptr[ASIZE-1:0]),
      .wdata (wdata),
      .ren   (rd_ok),
      .raddr (rptr[ASIZE-1:0]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo_param;

   logic       clk;
   logic       rst;
   logic       winc;
   logic [7:0] wdata;
   logic       wfull;
   logic       walmost_full;
   logic       rinc;
   logic [7:0] rdata;
   logic       rempty;
   logic       ralmost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int unsigned n_checks;
   int unsigned n_fail;

   sync_fifo_param #(
      .DSIZE     (8),
      .ASIZE     (4),
      .AFULL_TH  (14),
      .AEMPTY_TH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .winc          (winc),
      .wdata         (wdata),
      .wfull         (wfull),
      .walmost_full  (walmost_full),
      .rinc          (rinc),
      .rdata         (rdata),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .count         (count),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}
   function automatic logic [31:0] flag_vec();
      return {26'd0, wfull, walmost_full, rempty, ralmost_empty, overflow, underflow};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      winc     = 1'b0;
      rinc     = 1'b0;
      wdata    = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_flags", flag_vec(), 32'b001100);
      check("rst_count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("rst_rdata", 32'(rdata), 32'h00);
`endif
      rst = 1'b0;

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         winc  = 1'b1;
         wdata = 8'(i);
         tick();
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_afull", 32'(walmost_full), 32'((i + 1) >= 14));
         check("fill_full", 32'(wfull), 32'((i + 1) == 16));
      end
      wdata = 8'hAA;
      tick();
      winc = 1'b0;
      check("ovf_count", 32'(count), 32'd16);
      check("ovf_flags", flag_vec(), 32'b110010);

      // Drain: 0x00..0x0F in order
      rinc = 1'b1;
      for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("drain_data", 32'(rdata), 32'(i));
         tick();
`else
         tick();
         check("drain_data", 32'(rdata), 32'(i));
`endif
         check("drain_count", 32'(count), 32'(15 - i));
      end
      rinc = 1'b0;
      check("drain_flags", flag_vec(), 32'b001110);

      // Underflow
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      check("udf_flags", flag_vec(), 32'b001111);
      check("udf_count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("udf_rdata", 32'(rdata), 32'h0F);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("udf_clear", flag_vec(), 32'b001100);

      // Wrap-around with count held at 5
      winc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wdata = 8'(8'h10 + i);
         tick();
      end
      check("wrap_pre", 32'(count), 32'd5);
      rinc = 1'b1;
      for (int k = 0; k < 40; k++) begin
         wdata = 8'(8'h15 + k);
`ifdef SYNC_FIFO_FWFT_EN
         check("wrap_data", 32'(rdata), 32'(8'h10 + k));
         tick();
`else
         tick();
         check("wrap_data", 32'(rdata), 32'(8'h10 + k));
`endif
         check("wrap_count", 32'(count), 32'd5);
         check("wrap_flags", flag_vec(), 32'b000000);
      end
      rinc = 1'b0;

      // Holding 0x38..0x3C; top up with 0x3D..0x47 to reach full
      for (int i = 0; i < 11; i++) begin
         wdata = 8'(8'h3D + i);
         tick();
      end
      check("top_count", 32'(count), 32'd16);
      check("top_full", 32'(wfull), 32'd1);

      // Full plus simultaneous access: read wins, write dropped
      wdata = 8'hEE;
      rinc  = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      check("fsim_data", 32'(rdata), 32'h38);
`endif
      tick();
      winc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      check("fsim_data", 32'(rdata), 32'h38);
`endif
      check("fsim_count", 32'(count), 32'd15);
      check("fsim_flags", flag_vec(), 32'b010010);
      for (int i = 0; i < 15; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("fsim_drain", 32'(rdata), 32'(8'h39 + i));
         tick();
`else
         tick();
         check("fsim_drain", 32'(rdata), 32'(8'h39 + i));
`endif
      end
      rinc = 1'b0;
      check("fsim_empty", 32'(rempty), 32'd1);

      // Reset mid-operation discards data; next write lands at address 0
      winc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wdata = 8'(8'h60 + i);
         tick();
      end
      winc = 1'b0;
      rst  = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_flags", flag_vec(), 32'b001100);
      winc  = 1'b1;
      wdata = 8'h77;
      tick();
      winc = 1'b0;
      check("mrst_wr_count", 32'(count), 32'd1);
      rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      check("mrst_data", 32'(rdata), 32'h77);
      tick();
`else
      tick();
      check("mrst_data", 32'(rdata), 32'h77);
`endif
      rinc = 1'b0;
      check("mrst_empty", 32'(rempty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
      // Write to empty: head visible next cycle with no rinc
      winc  = 1'b1;
      wdata = 8'h5C;
      tick();
      winc = 1'b0;
      check("fwft_rempty", 32'(rempty), 32'd0);
      check("fwft_data", 32'(rdata), 32'h5C);
      tick();
      check("fwft_hold", 32'(rdata), 32'h5C);
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      check("fwft_ack", 32'(rempty), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
